// File: rtl/text_message_rom.sv
// Character source for the text overlay: fixed two-row messages with typewriter
// reveal and frame-synchronous blink; one cycle of latency from char_yx to char_code.
module text_message_rom #(
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int COLS       = 14,
  parameter int ROWS       = 2,
  parameter int MSG_W      = 2,
  parameter int CHAR_DELAY = 4,
  parameter int BLINK_HALF = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Y_W+X_W-1:0] char_yx,
  input  logic [MSG_W-1:0]   msg_sel,
  input  logic               start,
  input  logic               reveal_en,
  input  logic               blink_en,
  input  logic               frame_tick,
  output logic [7:0]         char_code,
  output logic               char_valid,
  output logic               reveal_done
);
  localparam int LW = $clog2(ROWS*COLS) + 1;
  localparam int TW = (CHAR_DELAY > 1) ? $clog2(CHAR_DELAY) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [LW-1:0] FULL = LW'(ROWS*COLS);

  typedef enum logic {S_REVEAL, S_SHOW} state_t;

  state_t           state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    blink_q, blink_d;
  logic             phase_q, phase_d;
  logic [7:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  // Message text is stored as ASCII with space mapped to the blank code 0x00.
  function automatic logic [7:0] rom_char(input logic [MSG_W-1:0] m,
                                          input logic [Y_W-1:0] y,
                                          input logic [X_W-1:0] x);
    logic [14*8-1:0] row;
    logic [7:0]      c;
    row = '0;
    c   = 8'h00;
    if (int'(y) == 0) begin
      case (int'(m))
        0:       row = "TO START PRESS";
        1:       row = "  GAME  OVER  ";
        2:       row = "    PAUSED    ";
        3:       row = "   YOU  WIN   ";
        default: row = '0;
      endcase
    end else if (int'(y) == 1) begin
      if (int'(m) == 0 || int'(m) == 1) row = "     RESET    ";
    end
    if (int'(x) < 14 && int'(x) < COLS && int'(y) < ROWS) begin
      c = row[8*(13-int'(x)) +: 8];
      if (c == 8'h20) c = 8'h00;
    end
    return c;
  endfunction

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [LW-1:0]  lin;
  logic           in_range;

  always_comb begin
    cx       = char_yx[X_W-1:0];
    cy       = char_yx[X_W +: Y_W];
    lin      = LW'(cy) * LW'(COLS) + LW'(cx);
    in_range = (int'(cx) < COLS) && (int'(cy) < ROWS);
    valid_d  = in_range && (lin < idx_q) && !(blink_en && phase_q);
    code_d   = valid_d ? rom_char(msg_q, cy, cx) : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (start) begin
      msg_d   = msg_sel;
      tick_d  = '0;
      blink_d = '0;
      phase_d = 1'b0;
      if (reveal_en) begin
        idx_d   = '0;
        state_d = S_REVEAL;
      end else begin
        idx_d   = FULL;
        state_d = S_SHOW;
      end
    end else if (frame_tick) begin
      if (blink_q == BW'(BLINK_HALF-1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
      if (state_q == S_REVEAL) begin
        if (tick_q == TW'(CHAR_DELAY-1)) begin
          tick_d = '0;
          idx_d  = idx_q + 1'b1;
          if (idx_d == FULL) state_d = S_SHOW;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
    end
    done_d = (state_d == S_SHOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SHOW;
      msg_q   <= '0;
      idx_q   <= FULL;
      tick_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign char_code   = code_q;
  assign char_valid  = valid_q;
  assign reveal_done = done_q;
endmodule

// File: tb/tb_text_message_rom.sv
// Directed bench for text_message_rom: read sweep, reveal, restart, blink,
// start/tick collision and asynchronous reset.
module tb_text_message_rom;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_yx = 8'h00;
  logic [1:0] msg_sel = 2'd0;
  logic       start = 1'b0;
  logic       reveal_en = 1'b0;
  logic       blink_en = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] char_code;
  logic       char_valid;
  logic       reveal_done;

  int errors = 0;
  int checks = 0;

  text_message_rom dut (
    .clk(clk), .rst(rst), .char_yx(char_yx), .msg_sel(msg_sel),
    .start(start), .reveal_en(reveal_en), .blink_en(blink_en),
    .frame_tick(frame_tick), .char_code(char_code),
    .char_valid(char_valid), .reveal_done(reveal_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a);
    char_yx = a;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic rev);
    msg_sel = m; reveal_en = rev; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_code", char_code, 8'h00);
    check("rst_valid", char_valid, 1'b0);
    check("rst_done", reveal_done, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: sweep every address against msg0, fully shown
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av;
      av = 8'(a);
      rd(av);
      check("sweep_valid", char_valid, (av[3:0] < 4'd14) && (av[7:4] < 4'd2));
      check("sweep_done", reveal_done, 1'b1);
      case (av)
        8'h00: check("sweep_00", char_code, 8'h54);
        8'h0d: check("sweep_0d", char_code, 8'h53);
        8'h15: check("sweep_15", char_code, 8'h52);
        8'h02, 8'h0e, 8'h1f, 8'h20: check("sweep_blank", char_code, 8'h00);
        default: ;
      endcase
    end

    // 2: typewriter reveal of msg1
    do_start(2'd1, 1'b1);
    rd(8'h02);
    check("rev_hidden_valid", char_valid, 1'b0);
    check("rev_hidden_code", char_code, 8'h00);
    check("rev_done0", reveal_done, 1'b0);
    ticks(4);
    rd(8'h00);
    check("rev1_valid", char_valid, 1'b1);
    check("rev1_code", char_code, 8'h00);
    rd(8'h01);
    check("rev1_next_hidden", char_valid, 1'b0);
    ticks(107);
    check("rev_done_early", reveal_done, 1'b0);
    ticks(1);
    check("rev_done_full", reveal_done, 1'b1);
    rd(8'h1d);
    check("rev_last_valid", char_valid, 1'b1);
    check("rev_last_code", char_code, 8'h00);

    // 3: restart mid-reveal with msg2
    do_start(2'd1, 1'b1);
    ticks(40);
    do_start(2'd2, 1'b1);
    ticks(16);
    rd(8'h04);
    check("restart_hidden", char_valid, 1'b0);
    ticks(4);
    rd(8'h04);
    check("restart_valid", char_valid, 1'b1);
    check("restart_code", char_code, 8'h50);

    // 4: immediate show of msg3 with blink
    do_start(2'd3, 1'b0);
    check("show_done", reveal_done, 1'b1);
    blink_en = 1'b1;
    ticks(29);
    rd(8'h03);
    check("blink_on_code", char_code, 8'h59);
    check("blink_on_valid", char_valid, 1'b1);
    ticks(1);
    rd(8'h03);
    check("blink_off_code", char_code, 8'h00);
    check("blink_off_valid", char_valid, 1'b0);
    ticks(29);
    rd(8'h03);
    check("blink_off2_valid", char_valid, 1'b0);
    ticks(1);
    rd(8'h03);
    check("blink_back_code", char_code, 8'h59);
    blink_en = 1'b0;

    // 5: start and frame_tick together, start wins
    do_start(2'd0, 1'b1);
    ticks(2);
    msg_sel = 2'd0; reveal_en = 1'b1; start = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; frame_tick = 1'b0;
    ticks(3);
    rd(8'h00);
    check("collide_hidden", char_valid, 1'b0);
    ticks(1);
    rd(8'h00);
    check("collide_code", char_code, 8'h54);

    // 6: asynchronous reset mid-reveal
    do_start(2'd2, 1'b1);
    ticks(10);
    rd(8'h00);
    check("pre_rst_done", reveal_done, 1'b0);
    check("pre_rst_valid", char_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_code", char_code, 8'h00);
    check("arst_valid", char_valid, 1'b0);
    check("arst_done", reveal_done, 1'b1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    rd(8'h1b);
    check("post_rst_done", reveal_done, 1'b1);
    check("post_rst_valid", char_valid, 1'b1);
    rd(8'h00);
    check("post_rst_code", char_code, 8'h54);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
